// File: rtl/serial_buffer_tx.sv
// serial_buffer_tx
//
// Transmits a frame of 1..32 bytes read from a 32-byte dual-port buffer as a
// slot-coded waveform on an open-drain line. Each bit takes 4 slots, and each
// slot takes SLOT_CYCLES clocks, sent MSB first:
//   1 -> 1 low slot, 3 released slots
//   0 -> 3 low slots, 1 released slot
// After the last bit the frame ends with a stop symbol: 1 low slot, then 1
// released slot. A one-cycle done pulse follows. All outputs are registered.
//
// Ports
//   clk         clock; all state changes on its rising edge
//   reset       synchronous, active-high reset
//   start       frame request; only looked at while idle
//   byte_count  bytes in the frame (1..32); sampled together with start
//   ram_addr    read address to the buffer
//   ram_data    asynchronous read data for ram_addr
//   tx_low      1 = pull the line low, 0 = release it
//   busy        high while a frame is in progress
//   done        one-cycle pulse after the frame completes

module serial_buffer_tx #(
    parameter int unsigned SLOT_CYCLES = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] byte_count,
    output logic [4:0] ram_addr,
    input  logic [7:0] ram_data,
    output logic       tx_low,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StBit, StStop} state_e;

    localparam logic [15:0] SlotLast = 16'(SLOT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  shift_q;
    logic [5:0]  count_q;    // bytes in the current frame
    logic [5:0]  loaded_q;   // bytes already loaded into shift_q
    logic [2:0]  bit_idx_q;
    logic [1:0]  slot_q;
    logic [15:0] timer_q;

    logic       count_ok;
    logic       timer_last;
    logic       slot_last;
    logic       bit_last;
    logic       byte_last;
    logic [1:0] slot_nxt;
    logic       bit_nxt;
    logic       tx_bit_nxt;

    // Next-cycle slot and bit value, so tx_low can be registered without
    // lagging the slot it belongs to.
    always_comb begin
        count_ok   = (byte_count != 6'd0) && (byte_count <= 6'd32);
        timer_last = (timer_q == SlotLast);
        slot_last  = timer_last && (slot_q == 2'd3);
        bit_last   = slot_last && (bit_idx_q == 3'd0);
        byte_last  = bit_last && (loaded_q == count_q);
        slot_nxt   = timer_last ? slot_q + 2'd1 : slot_q;
        if (bit_last) begin
            bit_nxt = ram_data[7];
        end else if (slot_last) begin
            bit_nxt = shift_q[bit_idx_q - 3'd1];
        end else begin
            bit_nxt = shift_q[bit_idx_q];
        end
        tx_bit_nxt = (slot_nxt == 2'd0) || ((slot_nxt != 2'd3) && !bit_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= 8'd0;
            count_q   <= 6'd0;
            loaded_q  <= 6'd0;
            bit_idx_q <= 3'd0;
            slot_q    <= 2'd0;
            timer_q   <= 16'd0;
            ram_addr  <= 5'd0;
            tx_low    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && count_ok) begin
                        state_q   <= StBit;
                        shift_q   <= ram_data;
                        count_q   <= byte_count;
                        loaded_q  <= 6'd1;
                        ram_addr  <= 5'd1;
                        bit_idx_q <= 3'd7;
                        slot_q    <= 2'd0;
                        timer_q   <= 16'd0;
                        tx_low    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                StBit: begin
                    timer_q <= timer_last ? 16'd0 : timer_q + 16'd1;
                    slot_q  <= slot_nxt;
                    if (byte_last) begin
                        state_q <= StStop;
                        tx_low  <= 1'b1;
                    end else begin
                        tx_low <= tx_bit_nxt;
                        if (bit_last) begin
                            // Next byte loads on the same edge: no gap cycle.
                            shift_q   <= ram_data;
                            loaded_q  <= loaded_q + 6'd1;
                            bit_idx_q <= 3'd7;
                            // Only a 32-byte frame loads from 31; stay there.
                            if (ram_addr != 5'd31) begin
                                ram_addr <= ram_addr + 5'd1;
                            end
                        end else if (slot_last) begin
                            bit_idx_q <= bit_idx_q - 3'd1;
                        end
                    end
                end

                StStop: begin
                    timer_q <= timer_last ? 16'd0 : timer_q + 16'd1;
                    if (timer_last) begin
                        if (slot_q == 2'd0) begin
                            slot_q <= 2'd1;
                            tx_low <= 1'b0;
                        end else begin
                            state_q   <= StIdle;
                            slot_q    <= 2'd0;
                            shift_q   <= 8'd0;
                            count_q   <= 6'd0;
                            loaded_q  <= 6'd0;
                            bit_idx_q <= 3'd0;
                            ram_addr  <= 5'd0;
                            tx_low    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_buffer_tx.sv
// Bench for serial_buffer_tx with SLOT_CYCLES=4: a reset/idle vector table,
// hand-written frame scenarios and random frames checked against a
// waveform model derived from the slot-coding rules.

module tb_serial_buffer_tx;

    localparam int unsigned S        = 4;
    localparam int          BYTE_CYC = 32 * S;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] byte_count;
    logic [4:0] ram_addr;
    logic [7:0] ram_data;
    logic       tx_low;
    logic       busy;
    logic       done;

    logic [7:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    assign ram_data = mem[ram_addr];

    always #5 clk = ~clk;

    serial_buffer_tx #(.SLOT_CYCLES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .tx_low     (tx_low),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Expected line level at cycle r (0..BYTE_CYC-1) of byte b.
    function automatic bit model_tx(input logic [7:0] b, input int r);
        int bit_pos;
        int slot;
        bit_pos = 7 - r / (4 * S);
        slot    = (r % (4 * S)) / S;
        return (slot == 0) || ((slot < 3) && (b[bit_pos] == 1'b0));
    endfunction

    // Called at a negedge with the DUT idle: presents start, follows the whole
    // frame against the model and returns at the done cycle. pulse_at injects a
    // one-cycle start mid-frame; hold keeps start high throughout.
    task automatic check_frame(input string name, input int n, input int wr_pct,
                               input int pulse_at, input bit hold);
        logic [7:0] bytes [32];
        int len;
        int e_busy;
        int e_tx;
        int e_addr;
        int e_done;
        len    = (32 * n + 2) * S;
        e_busy = 0;
        e_tx   = 0;
        e_addr = 0;
        e_done = 0;
        start      = 1'b1;
        byte_count = 6'(n);
        bytes[0]   = mem[0];
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < len; k++) begin
            int b;
            int r;
            int exp_addr;
            bit exp_tx;
            if (k < 32 * n * S) begin
                b        = k / BYTE_CYC;
                r        = k % BYTE_CYC;
                exp_tx   = model_tx(bytes[b], r);
                exp_addr = (b + 1 > 31) ? 31 : b + 1;
            end else begin
                b        = n;
                r        = 0;
                exp_tx   = ((k - 32 * n * S) / S) == 0;
                exp_addr = (n > 31) ? 31 : n;
            end
            if (busy !== 1'b1) e_busy++;
            if (tx_low !== exp_tx) e_tx++;
            if (ram_addr !== 5'(exp_addr)) e_addr++;
            if (done !== 1'b0) e_done++;
            if (!hold) begin
                start      = (k == pulse_at);
                byte_count = 6'd1;
            end
            if ($urandom_range(99) < wr_pct) mem[$urandom_range(31)] = 8'($urandom);
            // The next byte is whatever the buffer holds on its load edge.
            if ((k < 32 * n * S) && (r == BYTE_CYC - 1) && (b + 1 < n)) bytes[b + 1] = mem[b + 1];
            @(negedge clk);
        end
        start = hold;
        check({name, " busy-low cycles in frame"}, e_busy, 0);
        check({name, " tx_low wrong cycles"}, e_tx, 0);
        check({name, " ram_addr wrong cycles"}, e_addr, 0);
        check({name, " done inside frame"}, e_done, 0);
        check({name, " done-cycle busy"}, busy, 0);
        check({name, " done-cycle done"}, done, 1);
        check({name, " done-cycle tx_low"}, tx_low, 0);
        check({name, " done-cycle ram_addr"}, ram_addr, 0);
    endtask

    typedef struct packed {
        logic       rst;
        logic       st;
        logic [5:0] cnt;
        logic       busy;
        logic       tx;
        logic       done;
        logic [4:0] addr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int e;
        reset      = 1'b1;
        start      = 1'b0;
        byte_count = 6'd0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);

        //            rst   st    cnt     busy  tx    done  addr
        vecs[0]  = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b1, 1'b1, 6'd1,  1'b0, 1'b0, 1'b0, 5'd0};
        vecs[2]  = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 5'd0};
        vecs[3]  = '{1'b0, 1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[4]  = '{1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[5]  = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 5'd0};
        vecs[6]  = '{1'b0, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 5'd0};
        vecs[7]  = '{1'b0, 1'b1, 6'd1,  1'b1, 1'b1, 1'b0, 5'd1};
        vecs[8]  = '{1'b0, 1'b0, 6'd1,  1'b1, 1'b1, 1'b0, 5'd1};
        vecs[9]  = '{1'b0, 1'b1, 6'd2,  1'b1, 1'b1, 1'b0, 5'd1};
        vecs[10] = '{1'b0, 1'b0, 6'd2,  1'b1, 1'b1, 1'b0, 5'd1};
        vecs[11] = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 5'd0};
        vecs[12] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 5'd0};

        for (int i = 0; i < 13; i++) begin
            reset      = vecs[i].rst;
            start      = vecs[i].st;
            byte_count = vecs[i].cnt;
            @(negedge clk);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d tx_low", i), tx_low, vecs[i].tx);
            check($sformatf("vec%0d done", i), done, vecs[i].done);
            check($sformatf("vec%0d ram_addr", i), ram_addr, vecs[i].addr);
        end

        // Outputs must not react to start before a clock edge.
        start      = 1'b1;
        byte_count = 6'd1;
        #1;
        check("no comb path busy", busy, 0);
        check("no comb path tx_low", tx_low, 0);
        start = 1'b0;
        @(negedge clk);

        // Invalid counts: nothing happens for 20 cycles.
        e = 0;
        for (int k = 0; k < 20; k++) begin
            start      = 1'b1;
            byte_count = (k < 10) ? 6'd0 : 6'd33;
            @(negedge clk);
            if (busy !== 1'b0 || tx_low !== 1'b0 || done !== 1'b0) e++;
        end
        start = 1'b0;
        check("D invalid count activity", e, 0);

        // A: single byte 0xA5, then a single done pulse.
        mem[0] = 8'hA5;
        check_frame("A", 1, 0, -1, 1'b0);
        @(negedge clk);
        check("A done after pulse", done, 0);
        check("A busy after pulse", busy, 0);

        // B: byte boundary without a gap.
        mem[0] = 8'hFF;
        mem[1] = 8'h00;
        check_frame("B", 2, 0, -1, 1'b0);
        @(negedge clk);

        // C: full 32-byte buffer.
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        check_frame("C", 32, 0, -1, 1'b0);
        @(negedge clk);

        // E: restart attempt and reset abort mid-frame.
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
        start      = 1'b1;
        byte_count = 6'd3;
        @(negedge clk);
        e = 0;
        for (int k = 0; k < 50; k++) begin
            if (busy !== 1'b1) e++;
            start      = (k == 10);
            byte_count = 6'd1;
            @(negedge clk);
        end
        check("E busy before abort", e, 0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("E abort tx_low", tx_low, 0);
        check("E abort busy", busy, 0);
        check("E abort done", done, 0);
        check("E abort ram_addr", ram_addr, 0);
        start      = 1'b1;
        byte_count = 6'd1;
        @(negedge clk);
        check("E start under reset busy", busy, 0);
        check("E start under reset done", done, 0);
        reset = 1'b0;
        check_frame("E fresh", 1, 0, -1, 1'b0);
        @(negedge clk);

        // F: start held high, frames run back to back.
        mem[0] = 8'h3C;
        check_frame("F1", 1, 0, -1, 1'b1);
        mem[0] = 8'hC3;
        check_frame("F2", 1, 0, -1, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("F idle after release busy", busy, 0);
        check("F idle after release done", done, 0);

        // Random frames with buffer writes and mid-frame start pulses.
        for (int t = 0; t < 8; t++) begin
            int n;
            int gap;
            n = ($urandom_range(3) == 0) ? int'($urandom_range(1, 32)) : int'($urandom_range(1, 4));
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) begin
                start      = 1'b1;
                byte_count = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
                @(negedge clk);
                check($sformatf("R%0d invalid start busy", t), busy, 0);
            end
            check_frame($sformatf("R%0d n=%0d", t, n), n, 5,
                        int'($urandom_range(0, (32 * n + 2) * S - 2)), 1'b0);
            @(negedge clk);
            check($sformatf("R%0d done after pulse", t), done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_buffer_tx.md
SERIAL_BUFFER_TX -- requirements
Module: serial_buffer_tx

Interface
REQ-001 Parameter: SLOT_CYCLES, default 25, clk cycles per waveform slot (1 us at 25 MHz); legal range 2..65535.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to transmit a frame; sampled only in IDLE.
REQ-005 Port: byte_count  input  6  number of bytes in the frame; legal values 1..32; sampled with start.
REQ-006 Port: ram_addr  output  5  read address to the read port of the 32-byte dual-port buffer.
REQ-007 Port: ram_data  input  8  asynchronous read data for ram_addr, valid in the same cycle.
REQ-008 Port: tx_low  output  1  1 = drive the open-drain line low, 0 = release it.
REQ-009 Port: busy  output  1  high while a frame is in progress.
REQ-010 Port: done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 The block SHALL have three states: IDLE, BIT, STOP.
REQ-012 In IDLE the block SHALL hold ram_addr=0, tx_low=0, busy=0.
REQ-013 In IDLE, start=1 with byte_count in 1..32 SHALL be accepted on that edge: latch ram_data (byte 0) into the shift register, latch byte_count, set ram_addr=1, bit index=7, slot=0, slot timer=0, and enter BIT.
REQ-014 start with byte_count=0 or >32 SHALL be ignored: no state change, and busy and done both stay 0.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 busy SHALL be 1 in BIT and STOP, with its first high cycle being the cycle after acceptance.
REQ-017 Each bit SHALL occupy 4 slots of SLOT_CYCLES cycles each, transmitted MSB first.
REQ-018 In BIT, tx_low SHALL equal (slot==0) OR (slot<3 AND current bit==0).
  - bit 1: 1 low slot, then 3 released slots.
  - bit 0: 3 low slots, then 1 released slot.
REQ-019 The slot timer SHALL count 0..SLOT_CYCLES-1; at terminal count it SHALL wrap to 0 and advance the slot (0..3); at slot 3 terminal it SHALL advance to the next bit.
REQ-020 At the final cycle of bit 0 of a byte that is not the last byte, the block SHALL load ram_data into the shift register, increment ram_addr, and reset the bit index to 7 without a gap cycle.
REQ-021 At the final cycle of bit 0 of the last byte, the block SHALL enter STOP.
REQ-022 STOP SHALL drive tx_low=1 for one slot, then tx_low=0 for one slot.
REQ-023 At the final STOP cycle, the next state SHALL be IDLE, with done=1 for exactly that following cycle and busy=0.
REQ-024 Total busy duration SHALL be exactly (32*N+2)*SLOT_CYCLES cycles for N bytes.
REQ-025 Buffer writes during a frame are permitted; each byte's value SHALL be the ram_data present on its load cycle.
REQ-026 ram_addr SHALL never exceed byte_count; the value 32 is unreachable because the last load occurs at ram_addr=31.
REQ-027 start asserted in the done cycle SHALL be accepted, since that cycle is IDLE.
REQ-028 All outputs SHALL be registered; there is no combinational path from start to tx_low or busy.

Reset
REQ-029 While reset=1, the cycle following the edge SHALL have state=IDLE, tx_low=0, busy=0, done=0, ram_addr=0, and all counters=0.
REQ-030 reset asserted mid-frame SHALL abort the frame: the line is released, no done pulse is issued, and start is accepted on the first edge after reset deasserts.

Verification (SLOT_CYCLES=4)
REQ-031 Scenario A: buffer[0]=0xA5, start, count=1 -> tx_low pattern per bit, 1: 4 low/12 high, 0: 12 low/4 high; order 1,0,1,0,0,1,0,1; then 4 low, 4 high; busy high 136 cycles; done single pulse.
REQ-032 Scenario B: buffer[0..1]=0xFF,0x00, count=2 -> no gap cycle at the byte boundary; ram_addr 1 then 2; busy 264 cycles.
REQ-033 Scenario C: count=32 with buffer[i]=i -> bytes sent 0x00..0x1F in order; ram_addr max 31; busy 4104 cycles.
REQ-034 Scenario D: count=0, then count=33 -> busy, tx_low and done stay 0 for 20 cycles.
REQ-035 Scenario E: start pulsed again mid-frame, then reset at cycle 50 -> second start has no effect; on the next cycle tx_low=0, busy=0, done never asserts; a fresh start with count=1 completes normally.
REQ-036 Scenario F: start held high continuously, count=1 -> back-to-back frames; the second frame's first tx_low cycle immediately follows the done cycle.
